cycle_sequencer: RTL and testbench

CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

---
 rtl/cycle_sequencer.sv | 165 ++++++++++++++++
 tb/tb_cycle_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cycle_sequencer.sv
// cycle_sequencer: multicycle FETCH/DECODE/EXEC/MEM/WB control FSM with
// memory-wait timeout, halt handling and a retired-instruction counter.
// Ports:
//   CLK, nRST                  clock, async active-low reset
//   ihit, dhit                 imem / dmem access complete this cycle
//   DatRead, DatWrite, RegWr   decoded control for the instruction in IR
//   Halt                       decoded halt for the instruction in IR
//   imemREN                    instruction fetch request
//   dmemREN, dmemWEN           data read / write request
//   ir_en                      load instruction register
//   reg_wen                    register file write enable
//   pc_en                      advance PC, marks retirement
//   halt, timeout              halted status, sticky memory-timeout flag
//   instr_count                retired-instruction counter
//   state                      current state encoding
module cycle_sequencer #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        DatRead,
  input  logic        DatWrite,
  input  logic        RegWr,
  input  logic        Halt,
  output logic        imemREN,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic        ir_en,
  output logic        reg_wen,
  output logic        pc_en,
  output logic        halt,
  output logic        timeout,
  output logic [31:0] instr_count,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALTED = 3'd6
  } stateT;

  localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

  stateT      curState;
  stateT      nextState;
  logic [7:0] waitCnt;
  logic [7:0] waitNext;
  logic       timeoutNext;
  logic       atLimit;
  logic       memRead;

  assign atLimit = (waitCnt == LIMIT_M1);
  // write wins when both DatRead and DatWrite are set
  assign memRead = DatRead & ~DatWrite;
  assign state   = curState;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      curState    <= IDLE;
      waitCnt     <= '0;
      timeout     <= 1'b0;
      instr_count <= '0;
    end else begin
      curState <= nextState;
      waitCnt  <= waitNext;
      timeout  <= timeoutNext;
      if (pc_en)
        instr_count <= instr_count + 32'd1;
    end
  end

  always_comb begin
    nextState   = curState;
    waitNext    = waitCnt;
    timeoutNext = timeout;
    imemREN     = 1'b0;
    dmemREN     = 1'b0;
    dmemWEN     = 1'b0;
    ir_en       = 1'b0;
    reg_wen     = 1'b0;
    pc_en       = 1'b0;
    halt        = 1'b0;

    unique case (curState)
      IDLE: begin
        nextState = FETCH;
        waitNext  = '0;
      end

      FETCH: begin
        imemREN = 1'b1;
        if (ihit) begin
          ir_en     = 1'b1;
          nextState = DECODE;
        end else if (atLimit) begin
          nextState   = HALTED;
          timeoutNext = 1'b1;
        end else begin
          waitNext = waitCnt + 8'd1;
        end
      end

      DECODE: begin
        nextState = EXEC;
      end

      EXEC: begin
        if (Halt) begin
          nextState = HALTED;
        end else if (DatRead || DatWrite) begin
          nextState = MEM;
          waitNext  = '0;
        end else if (RegWr) begin
          nextState = WB;
        end else begin
          pc_en     = 1'b1;
          nextState = FETCH;
          waitNext  = '0;
        end
      end

      MEM: begin
        dmemWEN = DatWrite;
        dmemREN = memRead;
        if (dhit) begin
          if (memRead) begin
            nextState = WB;
          end else begin
            pc_en     = 1'b1;
            nextState = FETCH;
            waitNext  = '0;
          end
        end else if (atLimit) begin
          nextState   = HALTED;
          timeoutNext = 1'b1;
        end else begin
          waitNext = waitCnt + 8'd1;
        end
      end

      WB: begin
        reg_wen   = 1'b1;
        pc_en     = 1'b1;
        nextState = FETCH;
        waitNext  = '0;
      end

      HALTED: begin
        halt = 1'b1;
      end

      default: begin
        nextState = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cycle_sequencer.sv
// tb_cycle_sequencer: randomized program against a transaction-level model;
// expected retire/halt events are queued and checked by a monitor.
module tb_cycle_sequencer;

  localparam int WL = 16;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit = 1'b0;
  logic        dhit = 1'b0;
  logic        DatRead = 1'b0;
  logic        DatWrite = 1'b0;
  logic        RegWr = 1'b0;
  logic        Halt = 1'b0;
  logic        imemREN;
  logic        dmemREN;
  logic        dmemWEN;
  logic        ir_en;
  logic        reg_wen;
  logic        pc_en;
  logic        halt;
  logic        timeout;
  logic [31:0] instr_count;
  logic [2:0]  state;

  cycle_sequencer #(.WAIT_LIMIT(WL)) dut (
    .CLK(CLK),
    .nRST(nRST),
    .ihit(ihit),
    .dhit(dhit),
    .DatRead(DatRead),
    .DatWrite(DatWrite),
    .RegWr(RegWr),
    .Halt(Halt),
    .imemREN(imemREN),
    .dmemREN(dmemREN),
    .dmemWEN(dmemWEN),
    .ir_en(ir_en),
    .reg_wen(reg_wen),
    .pc_en(pc_en),
    .halt(halt),
    .timeout(timeout),
    .instr_count(instr_count),
    .state(state)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit isHalt;
    bit tmo;
    bit wen;
    bit ir;
    bit dr;
    bit dw;
    bit rw;
    bit hl;
    int lat;
    int cnt;
  } expT;

  expT sb[$];
  int  nChecks = 0;
  int  nErr = 0;
  bit  needReset = 0;

  int  longI[5] = '{13, 14, 15, 16, 20};
  int  longD[5] = '{7, 14, 15, 16, 20};
  int  iDelay, dDelay, iCnt, dCnt;
  bit  haveNext;
  int  expCount;
  expT cur;

  int  mLat;
  int  mIr;
  bit  mHaltSeen;
  expT me;

  task automatic check(string name, longint act, longint exp);
    nChecks++;
    if (act != exp) begin
      nErr++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic longint outs();
    return longint'({imemREN, dmemREN, dmemWEN, ir_en, reg_wen,
                     pc_en, halt, timeout, state, instr_count});
  endfunction

  task automatic doReset();
    nRST = 1'b0;
    #1;
    check("rst_outs", outs(), 0);
    ihit = 1'b1;
    dhit = 1'b1;
    DatRead = 1'($urandom_range(0, 1));
    DatWrite = 1'($urandom_range(0, 1));
    RegWr = 1'b1;
    @(negedge CLK);
    check("rst_hold", outs(), 0);
    @(negedge CLK);
    sb.delete();
    expCount = 0;
    haveNext = 0;
    needReset = 0;
    iCnt = 0;
    dCnt = 0;
    ihit = 1'b0;
    dhit = 1'b0;
    DatRead = 1'b0;
    DatWrite = 1'b0;
    RegWr = 1'b0;
    Halt = 1'b0;
    nRST = 1'b1;
    #1;
    check("post_release", outs(), 0);
  endtask

  task automatic genInstr();
    int  k;
    int  f;
    int  m;
    bit  retire;
    expT e;
    if ($urandom_range(0, 9) < 7) iDelay = $urandom_range(0, 3);
    else iDelay = longI[$urandom_range(0, 4)];
    if ($urandom_range(0, 9) < 7) dDelay = $urandom_range(0, 3);
    else dDelay = longD[$urandom_range(0, 4)];
    k = $urandom_range(0, 19);
    e = '{default: 0};
    e.cnt = expCount;
    f = iDelay + 1;
    m = dDelay + 1;
    retire = 0;
    if (k < 4) begin
      e.lat = f + 2;
      retire = 1;
    end else if (k < 8) begin
      e.rw = 1;
      e.wen = 1;
      e.lat = f + 3;
      retire = 1;
    end else if (k < 18) begin
      e.dr = (k < 12) || (k >= 15);
      e.dw = (k >= 12);
      e.rw = 1;
      if (dDelay >= WL) begin
        e.isHalt = 1;
        e.tmo = 1;
        e.lat = f + 2 + WL;
      end else begin
        e.wen = e.dr && !e.dw;
        e.lat = f + 2 + m + (e.wen ? 1 : 0);
        retire = 1;
      end
    end else begin
      e.hl = 1;
      e.isHalt = 1;
      e.lat = f + 2;
    end
    if (iDelay >= WL) begin
      e.isHalt = 1;
      e.tmo = 1;
      e.lat = WL;
      e.ir = 0;
      retire = 0;
    end else begin
      e.ir = 1;
    end
    if (retire) expCount++;
    cur = e;
    iCnt = 0;
    haveNext = 1;
    sb.push_back(e);
  endtask

  initial begin
    expCount = 0;
    haveNext = 0;
    iCnt = 0;
    dCnt = 0;
    doReset();
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge CLK);
      if (halt) begin
        @(negedge CLK);
        check("halt_absorb", longint'(state), 6);
        doReset();
        continue;
      end
      if (needReset) begin
        doReset();
        continue;
      end
      if (imemREN) begin
        if (!haveNext) genInstr();
        ihit = (iCnt == iDelay);
        iCnt++;
        if (ihit) begin
          DatRead = cur.dr;
          DatWrite = cur.dw;
          RegWr = cur.rw;
          Halt = cur.hl;
          haveNext = 0;
        end
      end else begin
        ihit = 1'($urandom_range(0, 1));
      end
      if (dmemREN || dmemWEN) begin
        if (dDelay == 7 && dCnt == 2) begin
          #2;
          doReset();
          continue;
        end
        dhit = (dCnt == dDelay);
        dCnt++;
      end else begin
        dhit = 1'($urandom_range(0, 1));
        dCnt = 0;
      end
    end
    repeat (3) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

  initial begin
    mLat = 0;
    mIr = 0;
    mHaltSeen = 0;
    forever begin
      @(negedge CLK);
      #1;
      if (!nRST || state == 3'd0) begin
        mLat = 0;
        mIr = 0;
        mHaltSeen = 0;
      end else if (halt) begin
        if (!mHaltSeen) begin
          mHaltSeen = 1;
          check("halted_outs",
                longint'({imemREN, dmemREN, dmemWEN, ir_en,
                          reg_wen, pc_en}), 0);
          if (sb.size() == 0) begin
            check("sb_empty_halt", 1, 0);
          end else begin
            me = sb.pop_front();
            check("halt_expected", longint'(me.isHalt), 1);
            check("timeout", longint'(timeout), longint'(me.tmo));
            check("count_at_halt", longint'(instr_count), me.cnt);
            check("halt_lat", mLat, me.lat);
            check("ir_pulses_halt", mIr, longint'(me.ir));
          end
        end
      end else begin
        mLat++;
        if (ir_en) mIr++;
        if ((dmemREN || dmemWEN) && sb.size() > 0) begin
          check("dmemWEN", longint'(dmemWEN), longint'(sb[0].dw));
          check("dmemREN", longint'(dmemREN),
                longint'(sb[0].dr && !sb[0].dw));
        end
        if (pc_en) begin
          if (sb.size() == 0) begin
            check("sb_empty_retire", 1, 0);
          end else begin
            me = sb.pop_front();
            check("retire_expected", longint'(me.isHalt), 0);
            check("reg_wen", longint'(reg_wen), longint'(me.wen));
            check("count", longint'(instr_count), me.cnt);
            check("lat", mLat, me.lat);
            check("ir_pulses", mIr, 1);
          end
          mLat = 0;
          mIr = 0;
        end else begin
          check("reg_wen_idle", longint'(reg_wen), 0);
        end
        if (mLat > 60) begin
          check("watchdog", mLat, 0);
          needReset = 1;
          mLat = 0;
        end
      end
    end
  end

endmodule
